// File: rtl/vx_wb_arbiter_if.sv
// Commit-request / writeback bus between the execute units and the writeback arbiter.
// master = requesters plus register-file side, slave = the arbiter itself.
interface vx_wb_arbiter_if #(
    parameter int NUM_REQS = 5,
    parameter int DATAW    = 64
) ();
    localparam int SELW = $clog2(NUM_REQS);

    logic [NUM_REQS-1:0]       valid_in;
    logic [NUM_REQS*DATAW-1:0] data_in;
    logic [NUM_REQS-1:0]       ready_out;
    logic                      valid_out;
    logic [DATAW-1:0]          data_out;
    logic [SELW-1:0]           sel_out;
    logic                      ready_in;

    modport master (
        output valid_in,
        output data_in,
        output ready_in,
        input  ready_out,
        input  valid_out,
        input  data_out,
        input  sel_out
    );

    modport slave (
        input  valid_in,
        input  data_in,
        input  ready_in,
        output ready_out,
        output valid_out,
        output data_out,
        output sel_out
    );
endinterface

// File: rtl/vx_wb_arbiter.sv
// Register-file writeback arbiter: round-robin grant with a starvation override,
// one-entry registered output stage and a saturating stall counter for perf CSRs.
module vx_wb_arbiter #(
    parameter int NUM_REQS = 5,
    parameter int DATAW    = 64,
    parameter int MAX_WAIT = 8
) (
    input  logic           clk,
    input  logic           reset,
    vx_wb_arbiter_if.slave wb,
    output logic [31:0]    stall_cnt
);
    localparam int SELW  = $clog2(NUM_REQS);
    localparam int WAITW = $clog2(MAX_WAIT + 1);
    localparam logic [WAITW-1:0] WAIT_MAX = WAITW'(MAX_WAIT);
    localparam logic [SELW-1:0]  LAST_IDX = SELW'(NUM_REQS - 1);
    localparam logic [SELW:0]    NUM_EXT  = (SELW + 1)'(NUM_REQS);

    logic                valid_out_r;
    logic [DATAW-1:0]    data_out_r;
    logic [SELW-1:0]     sel_out_r;
    logic [SELW-1:0]     rr_ptr_r;
    logic [31:0]         stall_cnt_r;
    logic [WAITW-1:0]    wait_r [NUM_REQS];

    logic                starved_any_s;
    logic [SELW-1:0]     starved_idx_s;
    logic                rr_found_s;
    logic [SELW-1:0]     rr_idx_s;
    logic [SELW:0]       cand_s;
    logic                grant_vld_s;
    logic [SELW-1:0]     grant_idx_s;
    logic                stage_en_s;
    logic                fire_s;
    logic [NUM_REQS-1:0] ready_s;

    function automatic logic [WAITW-1:0] sat_inc(input logic [WAITW-1:0] v);
        if (v >= WAIT_MAX) begin
            return WAIT_MAX;
        end else begin
            return v + WAITW'(1);
        end
    endfunction

    // Starved requesters: scan downwards so the lowest starved index is left selected.
    always_comb begin
        starved_any_s = 1'b0;
        starved_idx_s = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (wb.valid_in[i] && (wait_r[i] == WAIT_MAX)) begin
                starved_any_s = 1'b1;
                starved_idx_s = SELW'(i);
            end else begin
                starved_any_s = starved_any_s;
            end
        end
    end

    // Round-robin scan from rr_ptr with an explicit modulo wrap (NUM_REQS need not be a power of 2).
    always_comb begin
        rr_found_s = 1'b0;
        rr_idx_s   = '0;
        cand_s     = '0;
        for (int off = 0; off < NUM_REQS; off++) begin
            cand_s = {1'b0, rr_ptr_r} + (SELW + 1)'(off);
            if (cand_s >= NUM_EXT) begin
                cand_s = cand_s - NUM_EXT;
            end else begin
                cand_s = cand_s;
            end
            if (!rr_found_s && wb.valid_in[cand_s[SELW-1:0]]) begin
                rr_found_s = 1'b1;
                rr_idx_s   = cand_s[SELW-1:0];
            end else begin
                rr_found_s = rr_found_s;
            end
        end
    end

    // Final grant, stage enable and per-requester accept; nothing fires while reset is held.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        ready_s     = '0;
        if (starved_any_s) begin
            grant_vld_s = 1'b1;
            grant_idx_s = starved_idx_s;
        end else if (rr_found_s) begin
            grant_vld_s = 1'b1;
            grant_idx_s = rr_idx_s;
        end else begin
            grant_vld_s = 1'b0;
        end
        stage_en_s = !valid_out_r || wb.ready_in;
        fire_s     = grant_vld_s && stage_en_s && !reset;
        for (int i = 0; i < NUM_REQS; i++) begin
            ready_s[i] = fire_s && (grant_idx_s == SELW'(i));
        end
    end

    // Output stage, round-robin pointer, wait counters and stall counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out_r <= 1'b0;
            data_out_r  <= '0;
            sel_out_r   <= '0;
            rr_ptr_r    <= '0;
            stall_cnt_r <= 32'd0;
            for (int i = 0; i < NUM_REQS; i++) begin
                wait_r[i] <= '0;
            end
        end else begin
            if (fire_s) begin
                valid_out_r <= 1'b1;
                data_out_r  <= wb.data_in[int'(grant_idx_s) * DATAW +: DATAW];
                sel_out_r   <= grant_idx_s;
                rr_ptr_r    <= (grant_idx_s == LAST_IDX) ? '0 : grant_idx_s + SELW'(1);
            end else if (wb.ready_in) begin
                valid_out_r <= 1'b0;
            end else begin
                valid_out_r <= valid_out_r;
            end

            if (valid_out_r && !wb.ready_in && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end

            // ready_s[i] already implies valid_in[i], so it is exactly fire_i.
            for (int i = 0; i < NUM_REQS; i++) begin
                if (wb.valid_in[i] && !ready_s[i]) begin
                    wait_r[i] <= sat_inc(wait_r[i]);
                end else begin
                    wait_r[i] <= '0;
                end
            end
        end
    end

    assign wb.ready_out = ready_s;
    assign wb.valid_out = valid_out_r;
    assign wb.data_out  = data_out_r;
    assign wb.sel_out   = sel_out_r;
    assign stall_cnt    = stall_cnt_r;
endmodule

// File: tb/tb_vx_wb_arbiter.sv
// Directed bench for vx_wb_arbiter: reference model plus scoreboard queue of expected writebacks.
module tb_vx_wb_arbiter;
    localparam int N  = 5;
    localparam int DW = 64;
    localparam int SW = 3;

    typedef struct {
        int             sel;
        logic [DW-1:0]  data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic            cur;
    logic [N-1:0]    vin;
    logic [N*DW-1:0] din;
    logic            rdy;

    vx_wb_arbiter_if #(.NUM_REQS(N), .DATAW(DW)) if_a ();
    vx_wb_arbiter_if #(.NUM_REQS(N), .DATAW(DW)) if_b ();
    logic [31:0] stall_a;
    logic [31:0] stall_b;

    assign if_a.valid_in = cur ? '0 : vin;
    assign if_a.data_in  = din;
    assign if_a.ready_in = cur ? 1'b1 : rdy;
    assign if_b.valid_in = cur ? vin : '0;
    assign if_b.data_in  = din;
    assign if_b.ready_in = cur ? rdy : 1'b1;

    vx_wb_arbiter #(.NUM_REQS(N), .DATAW(DW), .MAX_WAIT(8)) u_dut (
        .clk(clk), .reset(reset), .wb(if_a), .stall_cnt(stall_a)
    );
    vx_wb_arbiter #(.NUM_REQS(N), .DATAW(DW), .MAX_WAIT(2)) u_mw2 (
        .clk(clk), .reset(reset), .wb(if_b), .stall_cnt(stall_b)
    );

    wire [N-1:0]  obs_ro    = cur ? if_b.ready_out : if_a.ready_out;
    wire          obs_vo    = cur ? if_b.valid_out : if_a.valid_out;
    wire [DW-1:0] obs_do    = cur ? if_b.data_out  : if_a.data_out;
    wire [SW-1:0] obs_sel   = cur ? if_b.sel_out   : if_a.sel_out;
    wire [31:0]   obs_stall = cur ? stall_b        : stall_a;

    int          errors;
    int          checks;
    int          mw;
    int          m_rr;
    int          m_wait [N];
    bit          m_vo;
    logic [31:0] m_stall;
    logic [DW-1:0] m_data;
    int          m_sel;
    exp_t        exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        for (int i = 0; i < N; i++) begin
            if (vin[i] && m_wait[i] == mw) return i;
        end
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_rr + k) % N;
            if (vin[j]) return j;
        end
        return -1;
    endfunction

    // One clock: check combinational accept, advance the model, then check the registered outputs.
    task automatic cycle();
        int           g;
        bit           en;
        bit           fire;
        logic [N-1:0] exp_ro;
        exp_t         e;
        #3;
        g      = model_grant();
        en     = !m_vo || rdy;
        fire   = (g >= 0) && en && !reset;
        exp_ro = '0;
        if (fire) begin
            exp_ro[g] = 1'b1;
            e.sel  = g;
            e.data = din[g*DW +: DW];
            exp_q.push_back(e);
        end
        chk("ready_out", 64'(obs_ro), 64'(exp_ro));
        @(posedge clk);
        #1;
        if (reset) begin
            m_vo    = 1'b0;
            m_rr    = 0;
            m_stall = 32'd0;
            m_data  = '0;
            m_sel   = 0;
            foreach (m_wait[i]) m_wait[i] = 0;
            exp_q.delete();
        end else begin
            if (m_vo && !rdy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
            for (int i = 0; i < N; i++) begin
                if (vin[i] && !(fire && g == i)) m_wait[i] = (m_wait[i] < mw) ? m_wait[i] + 1 : mw;
                else m_wait[i] = 0;
            end
            if (fire) begin
                m_vo   = 1'b1;
                m_rr   = (g + 1) % N;
                e      = exp_q.pop_front();
                m_data = e.data;
                m_sel  = e.sel;
                din[g*DW +: DW] = {$urandom(), $urandom()};
            end else if (rdy) begin
                m_vo = 1'b0;
            end
        end
        chk("valid_out", 64'(obs_vo), 64'(m_vo));
        chk("data_out", obs_do, m_data);
        chk("sel_out", 64'(obs_sel), 64'(m_sel));
        chk("stall_cnt", 64'(obs_stall), 64'(m_stall));
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cur    = 1'b0;
        mw     = 8;
        m_rr   = 0;
        m_vo   = 1'b0;
        m_stall = 32'd0;
        m_data = '0;
        m_sel  = 0;
        foreach (m_wait[i]) m_wait[i] = 0;
        reset  = 1'b1;
        rdy    = 1'b1;
        vin    = '0;
        for (int i = 0; i < N; i++) din[i*DW +: DW] = {$urandom(), $urandom()};

        // Reset state; a valid request during reset must not be accepted.
        cycle();
        vin = 5'b00100;
        cycle();
        reset = 1'b0;
        vin = '0;
        cycle();

        // Single request on lane 2.
        din[2*DW +: DW] = 64'hAB;
        vin = 5'b00100;
        cycle();
        chk("first_data", obs_do, 64'hAB);
        chk("first_sel", 64'(obs_sel), 64'd2);
        vin = '0;
        cycle();

        // All requesters valid: rotating grants, one writeback per cycle.
        vin = '1;
        for (int k = 0; k < 10; k++) cycle();

        // Backpressure with the output full, then drain and refill together.
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        chk("stall_three", 64'(obs_stall), 64'd3);
        rdy = 1'b1;
        cycle();
        cycle();

        // Grant 4 then the pointer must wrap to 0.
        vin = 5'b10000;
        cycle();
        chk("grant_four", 64'(obs_sel), 64'd4);
        vin = 5'b01111;
        cycle();
        chk("wrap_sel", 64'(obs_sel), 64'd0);
        vin = 5'b10000;
        cycle();
        vin = 5'b00001;
        cycle();
        chk("wrap_only0", 64'(obs_sel), 64'd0);

        // Reset with the output full and requesters pending.
        vin = '1;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        chk("rst_drop", 64'(obs_vo), 64'd0);
        reset = 1'b0;
        vin = 5'b11010;
        cycle();
        chk("post_rst_sel", 64'(obs_sel), 64'd1);
        vin = '0;
        cycle();

        // Starvation override on the MAX_WAIT=2 instance.
        cur   = 1'b1;
        mw    = 2;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        vin = 5'b10000;
        cycle();
        rdy = 1'b0;
        cycle();
        vin = 5'b10011;
        cycle();
        rdy = 1'b1;
        cycle();
        chk("starve_sel", 64'(obs_sel), 64'd4);
        vin = 5'b00011;
        cycle();
        cycle();
        vin = '0;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
